pipe_adder: RTL and testbench

Parametrised, pipelined integer adder/subtractor for the datapath. It splits a WIDTH-bit add or subtract into STAGES equal carry-chained slices, one slice per register stage, so the carry path per cycle is WIDTH/STAGES bits. It reports carry-out and signed overflow, and carries a destination tag alongside each result. It replaces the flat combinational adder wherever a long carry chain limits clock rate. A valid/ready handshake lets it sit between pipeline stages that stall or flush.

---
 rtl/adder_pkg.sv | 5 +
 rtl/adder_slice.sv | 14 +
 rtl/pipe_adder.sv | 101 ++++++++++
 tb/tb_pipe_adder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared opcode encodings for the pipelined adder
package adder_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational S-bit adder slice with carry and MSB overflow
module adder_slice #(
  parameter int S = 8
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         ci,
  output logic [S-1:0] sum,
  output logic         co,
  output logic         ovf
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, ci};
  assign ovf = (a[S-1] == b[S-1]) && (sum[S-1] != a[S-1]);
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-chained adder/subtractor with valid/ready and flush
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be divisible by STAGES");
  end
  logic                          en;
  logic [WIDTH-1:0]              b0;
  logic [STAGES-1:0][WIDTH-1:0]  a_n, b_n, s_n, a_q, b_q, s_q;
  logic [STAGES-1:0][TAG_W-1:0]  t_n, t_q;
  logic [STAGES-1:0]             c_n, o_n, v_n, c_q, o_q, v_q;
  assign en      = !valid_o || ready_i;
  assign ready_o = en;
  assign b0      = (op_i == OP_SUB) ? ~src2_i : src2_i;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] ai, bi, si;
    logic             ci;
    if (k == 0) begin : g_first
      assign ai     = src1_i;
      assign bi     = b0;
      assign si     = '0;
      assign ci     = (op_i == OP_SUB);
      assign t_n[k] = tag_i;
      assign v_n[k] = valid_i;
    end else begin : g_next
      assign ai     = a_q[k-1];
      assign bi     = b_q[k-1];
      assign si     = s_q[k-1];
      assign ci     = c_q[k-1];
      assign t_n[k] = t_q[k-1];
      assign v_n[k] = v_q[k-1];
    end
    adder_slice #(.S(S)) u_slice (
      .a   (ai[k*S +: S]),
      .b   (bi[k*S +: S]),
      .ci  (ci),
      .sum (s_n[k][k*S +: S]),
      .co  (c_n[k]),
      .ovf (o_n[k])
    );
    // finished low slices ride along de-skewed; unfinished high bits stay zero
    if (k > 0) begin : g_low
      assign s_n[k][k*S-1:0] = si[k*S-1:0];
    end
    if (k < L) begin : g_high
      assign s_n[k][WIDTH-1:(k+1)*S] = '0;
    end
    assign a_n[k] = ai;
    assign b_n[k] = bi;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      o_q <= '0;
      t_q <= '0;
      v_q <= '0;
    end else begin
      if (en) begin
        a_q <= a_n;
        b_q <= b_n;
        s_q <= s_n;
        c_q <= c_n;
        o_q <= o_n;
        t_q <= t_n;
        v_q <= v_n;
      end
      if (flush_i) v_q <= '0;
    end
  end
  assign valid_o    = v_q[L];
  assign sum_o      = s_q[L];
  assign carry_o    = c_q[L];
  assign overflow_o = o_q[L];
  assign tag_o      = t_q[L];
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and streamed checks of pipe_adder against an arithmetic model
module tb_pipe_adder;
  import adder_pkg::*;
  localparam int WIDTH = 32, STAGES = 4, TAG_W = 5;
  logic             clk = 0, rst_i = 1;
  logic             valid_i = 0, op_i = 0, flush_i = 0, ready_i = 1;
  logic [WIDTH-1:0] src1_i = 0, src2_i = 0;
  logic [TAG_W-1:0] tag_i = 0;
  logic             ready_o, valid_o, carry_o, overflow_o;
  logic [WIDTH-1:0] sum_o;
  logic [TAG_W-1:0] tag_o;
  int               checks = 0, errors = 0;
  logic [38:0]      q[$];
  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .tag_i(tag_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .carry_o(carry_o),
    .overflow_o(overflow_o), .tag_o(tag_o)
  );
  always #5 clk = ~clk;
  function automatic logic [38:0] model(logic op, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint r  = (op == OP_SUB) ? sa - sb : sa + sb;
    logic   c  = (op == OP_SUB) ? (ua >= ub) : (ua + ub > 64'hFFFF_FFFF);
    logic   o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    logic [31:0] s = r[31:0];
    return {s, c, o, t};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_i) q.delete();
    else begin
      chk("ready_o", 64'(ready_o), 64'(!(valid_o && !ready_i)));
      if (valid_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: valid_o=1 tag=%0d with nothing outstanding at %0t", tag_o, $time);
        end else begin
          chk("result", 64'({sum_o, carry_o, overflow_o, tag_o}), 64'(q[0]));
          if (ready_i) void'(q.pop_front());
        end
      end
      if (flush_i) q.delete();
      else if (valid_i && ready_o) q.push_back(model(op_i, src1_i, src2_i, tag_i));
    end
  end
  task automatic drive(logic op, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    valid_i = 1; op_i = op; src1_i = a; src2_i = b; tag_i = t;
    @(posedge clk); #1;
    valid_i = 0;
  endtask
  task automatic one_op(string name, logic op, logic [31:0] a, logic [31:0] b, logic [4:0] t,
                        logic [31:0] es, logic ec, logic eo);
    drive(op, a, b, t);
    repeat (STAGES - 2) @(posedge clk);
    #1 chk({name, "_early"}, 64'(valid_o), 64'(0));
    @(posedge clk); #1;
    chk({name, "_valid"}, 64'(valid_o), 64'(1));
    chk({name, "_sum"}, 64'(sum_o), 64'(es));
    chk({name, "_carry"}, 64'(carry_o), 64'(ec));
    chk({name, "_ovf"}, 64'(overflow_o), 64'(eo));
    chk({name, "_tag"}, 64'(tag_o), 64'(t));
    @(posedge clk); #1;
  endtask
  initial begin
    int n, i, acc;
    #2;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_sum", 64'(sum_o), 64'(0));
    chk("rst_flags", 64'({carry_o, overflow_o}), 64'(0));
    chk("rst_tag", 64'(tag_o), 64'(0));
    #10 rst_i = 0;
    #1 chk("rst_ready", 64'(ready_o), 64'(1));
    @(posedge clk); #1;
    one_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 1'b1, 1'b0);
    one_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd4, 32'h8000_0000, 1'b0, 1'b1);
    one_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 5'd5, 32'h7FFF_FFFF, 1'b1, 1'b1);
    one_op("sub_borrow", OP_SUB, 32'd5, 32'd7, 5'd6, 32'hFFFF_FFFE, 1'b0, 1'b0);
    one_op("sub_pos", OP_SUB, 32'd7, 32'd5, 5'd7, 32'd2, 1'b1, 1'b0);
    // eight back-to-back ops with ready_i low for cycles 4..6
    i = 0; n = 0;
    while (i < 8 && n < 40) begin
      ready_i = !(n >= 4 && n <= 6);
      valid_i = 1; op_i = 1'($urandom); src1_i = $urandom; src2_i = $urandom; tag_i = 5'(i + 16);
      #1 acc = int'(ready_o);
      @(posedge clk); #1;
      if (acc != 0) i++;
      n++;
    end
    valid_i = 0; ready_i = 1;
    chk("stream_accepted", 64'(i), 64'(8));
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("stream_drained", 64'(q.size()), 64'(0));
    drive(OP_ADD, 32'd10, 32'd20, 5'd1);
    drive(OP_SUB, 32'd10, 32'd20, 5'd2);
    drive(OP_ADD, 32'd1, 32'd1, 5'd3);
    valid_i = 1; flush_i = 1; op_i = OP_ADD; src1_i = 32'd99; src2_i = 32'd1; tag_i = 5'd9;
    @(posedge clk); #1;
    flush_i = 0; valid_i = 0;
    chk("flush_valid", 64'(valid_o), 64'(0));
    one_op("post_flush", OP_ADD, 32'h1234_5678, 32'h1111_1111, 5'd11, 32'h2345_6789, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("flush_quiet", 64'(valid_o), 64'(0));
    drive(OP_ADD, 32'd3, 32'd4, 5'd12);
    drive(OP_ADD, 32'd5, 32'd6, 5'd13);
    #2 rst_i = 1;
    #1;
    chk("arst_valid", 64'(valid_o), 64'(0));
    chk("arst_sum", 64'(sum_o), 64'(0));
    chk("arst_flags", 64'({carry_o, overflow_o}), 64'(0));
    chk("arst_tag", 64'(tag_o), 64'(0));
    #20 rst_i = 0;
    repeat (8) @(posedge clk); #1;
    chk("arst_no_stale", 64'(valid_o), 64'(0));
    one_op("after_rst", OP_SUB, 32'd0, 32'd1, 5'd30, 32'hFFFF_FFFF, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
